data_mem_arbiter: RTL and testbench

Two-port arbiter that shares the single data memory (RAM) between the MIPS core's load/store path and a DMA/loader requester (program loader or debug port). Sits between the core's ALU-result/ReadData2 path and the DataMemory instance. It serializes accesses through a three-state FSM and stalls the core while its access is pending. CPU has fixed priority, with a starvation counter that guarantees DMA progress.

---
 rtl/data_mem_arbiter.sv | 167 ++++++++++++++++
 tb/tb_data_mem_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: shares one asynchronous-read data memory between the CPU
// load/store path and a DMA/loader requester. Each access takes a fixed
// IDLE -> ACC -> DONE sequence. The CPU has priority, and a starvation counter
// ensures the DMA requester still makes progress under constant contention.
module data_mem_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_ack,
    output logic                  cpu_stall,
    input  logic                  dma_req,
    input  logic                  dma_we,
    input  logic [ADDR_WIDTH-1:0] dma_addr,
    input  logic [DATA_WIDTH-1:0] dma_wdata,
    output logic [DATA_WIDTH-1:0] dma_rdata,
    output logic                  dma_ack,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_we,
    output logic                  mem_re,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  grant_dma
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic                  r_cmd_we;
    logic [ADDR_WIDTH-1:0] r_cmd_addr;
    logic [DATA_WIDTH-1:0] r_cmd_wdata;
    logic                  r_owner_dma;
    logic [CNT_W-1:0]      r_starve_cnt;
    logic [DATA_WIDTH-1:0] r_cpu_rdata;
    logic [DATA_WIDTH-1:0] r_dma_rdata;

    logic w_grant;
    logic w_pick_dma;
    logic w_mem_we;
    logic w_mem_re;
    logic w_cpu_ack;
    logic w_dma_ack;

    // A grant happens only in IDLE; DMA wins when alone or when the CPU has
    // already been favoured STARVE_LIMIT times in a row while DMA waited.
    assign w_grant    = (r_state == S_IDLE) && (cpu_req || dma_req);
    assign w_pick_dma = dma_req && (!cpu_req || (r_starve_cnt == CNT_MAX));

    // State register; reset drops straight to IDLE so an in-flight write is cut.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and strobe/ack decode; strobes exist only in ACC, acks only in DONE.
    always_comb begin
        w_state_next = r_state;
        w_mem_we     = 1'b0;
        w_mem_re     = 1'b0;
        w_cpu_ack    = 1'b0;
        w_dma_ack    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (cpu_req || dma_req) begin
                    w_state_next = S_ACC;
                end
            end
            S_ACC: begin
                w_mem_we     = r_cmd_we;
                w_mem_re     = !r_cmd_we;
                w_state_next = S_DONE;
            end
            S_DONE: begin
                w_cpu_ack    = !r_owner_dma;
                w_dma_ack    = r_owner_dma;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Command registers capture the winner's request in the grant cycle only,
    // so later changes on the requester's bus are ignored.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cmd_we    <= 1'b0;
            r_cmd_addr  <= '0;
            r_cmd_wdata <= '0;
            r_owner_dma <= 1'b0;
        end else if (w_grant) begin
            r_owner_dma <= w_pick_dma;
            if (w_pick_dma) begin
                r_cmd_we    <= dma_we;
                r_cmd_addr  <= dma_addr;
                r_cmd_wdata <= dma_wdata;
            end else begin
                r_cmd_we    <= cpu_we;
                r_cmd_addr  <= cpu_addr;
                r_cmd_wdata <= cpu_wdata;
            end
        end
    end

    // Starvation counter: counts CPU wins over a waiting DMA, saturating;
    // any DMA grant or any cycle without a DMA request clears it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_starve_cnt <= '0;
        end else if (!dma_req) begin
            r_starve_cnt <= '0;
        end else if (w_grant) begin
            if (w_pick_dma) begin
                r_starve_cnt <= '0;
            end else if (r_starve_cnt != CNT_MAX) begin
                r_starve_cnt <= r_starve_cnt + CNT_W'(1);
            end
        end
    end

    // Read data lands in the owner's register at the end of a read ACC cycle;
    // the other requester's register and all writes leave it untouched.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cpu_rdata <= '0;
            r_dma_rdata <= '0;
        end else if ((r_state == S_ACC) && !r_cmd_we) begin
            if (r_owner_dma) begin
                r_dma_rdata <= mem_rdata;
            end else begin
                r_cpu_rdata <= mem_rdata;
            end
        end
    end

    assign mem_addr  = r_cmd_addr;
    assign mem_wdata = r_cmd_wdata;
    assign mem_we    = w_mem_we;
    assign mem_re    = w_mem_re;
    assign cpu_ack   = w_cpu_ack;
    assign dma_ack   = w_dma_ack;
    assign cpu_rdata = r_cpu_rdata;
    assign dma_rdata = r_dma_rdata;
    assign grant_dma = r_owner_dma;
    // Stall is purely a function of the request and ack, independent of reset.
    assign cpu_stall = cpu_req && !w_cpu_ack;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Testbench for data_mem_arbiter: a word-addressed RAM stands in for
// DataMemory, and a reference memory plus expected-grant rules predict results.
module tb_data_mem_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int LIM = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          cpu_req, cpu_we, dma_req, dma_we;
    logic [AW-1:0] cpu_addr, dma_addr, mem_addr;
    logic [DW-1:0] cpu_wdata, dma_wdata, cpu_rdata, dma_rdata, mem_wdata, mem_rdata;
    logic          cpu_ack, cpu_stall, dma_ack, mem_we, mem_re, grant_dma;

    always #5 clk = ~clk;

    data_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(LIM)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_rdata(dma_rdata), .dma_ack(dma_ack),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
        .mem_rdata(mem_rdata), .grant_dma(grant_dma)
    );

    // Data memory stand-in: asynchronous read, synchronous write.
    logic        ram_init;
    logic [31:0] ram [0:255];
    assign mem_rdata = ram[mem_addr[9:2]];
    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 256; i++) ram[i] <= 32'h0;
        end else if (mem_we) begin
            ram[mem_addr[9:2]] <= mem_wdata;
        end
    end

    // Reference memory contents as the specification says they should be.
    logic [31:0] ref_mem [0:255];

    int pass_cnt = 0;
    int total_cnt = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Record every memory strobe: which requester owned it and when.
    int mon_cyc[$];
    bit mon_dma[$];
    always @(negedge clk) begin
        if (mem_we || mem_re) begin
            mon_cyc.push_back(cyc);
            mon_dma.push_back(grant_dma);
        end
    end

    // Drive one solo access and trace it; sample index k is the k-th falling
    // edge after the request is raised (k=0 lies in the grant cycle N).
    task automatic run_access(input bit is_dma, input bit we, input logic [31:0] addr,
                              input logic [31:0] wdata, output int lat, output logic [31:0] rd,
                              output logic [7:0] we_tr, output logic [7:0] stall_tr);
        lat = -1; rd = '0; we_tr = '0; stall_tr = '0;
        @(posedge clk); #1;
        if (is_dma) begin
            dma_req = 1'b1; dma_we = we; dma_addr = addr; dma_wdata = wdata;
        end else begin
            cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            we_tr[k] = mem_we;
            stall_tr[k] = cpu_stall;
            if (k == 1) begin
                // After the grant the requester bus is scrambled; it must not matter.
                if (is_dma) begin dma_addr = ~addr; dma_wdata = ~wdata; end
                else begin cpu_addr = ~addr; cpu_wdata = ~wdata; end
            end
            if (is_dma ? dma_ack : cpu_ack) begin
                lat = k;
                rd = is_dma ? dma_rdata : cpu_rdata;
                break;
            end
        end
        @(posedge clk); #1;
        cpu_req = 1'b0; dma_req = 1'b0;
        $display("txn %s %s addr=0x%08h wdata=0x%08h lat=%0d rdata=0x%08h",
                 is_dma ? "DMA" : "CPU", we ? "WR" : "RD", addr, wdata, lat, rd);
    endtask

    task automatic test_reset();
        int bad;
        reset = 1'b1; ram_init = 1'b1;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total_cnt++;
        if ({mem_we, mem_re, cpu_ack, dma_ack, grant_dma} !== 5'b0) begin
            $display("FAIL reset_ctrl: got %b expected 00000", {mem_we, mem_re, cpu_ack, dma_ack, grant_dma});
        end else pass_cnt++;
        total_cnt++;
        if ({mem_addr, mem_wdata, cpu_rdata, dma_rdata} !== '0) begin
            $display("FAIL reset_data: addr=%h wdata=%h crd=%h drd=%h expected all 0",
                     mem_addr, mem_wdata, cpu_rdata, dma_rdata);
        end else pass_cnt++;
        // Stall follows cpu_req even while reset is held.
        cpu_req = 1'b1; #1;
        total_cnt++;
        if (cpu_stall !== 1'b1) $display("FAIL stall_in_reset: got %b expected 1", cpu_stall);
        else pass_cnt++;
        cpu_req = 1'b0;
        @(negedge clk);
        reset = 1'b0; ram_init = 1'b0;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (mem_we || mem_re || cpu_ack || dma_ack || grant_dma || cpu_stall) bad++;
        end
        total_cnt++;
        if (bad != 0) $display("FAIL idle_quiet: active cycles=%0d expected 0", bad);
        else pass_cnt++;
    endtask

    task automatic test_cpu_store_load();
        int lat; logic [31:0] rd; logic [7:0] wt, st;
        run_access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, lat, rd, wt, st);
        ref_mem[4] = 32'hDEADBEEF;
        total_cnt++;
        if (lat != 2) $display("FAIL store_latency: got %0d expected 2", lat); else pass_cnt++;
        total_cnt++;
        if (wt[2:0] !== 3'b010) $display("FAIL store_we_trace: got %b expected 010", wt[2:0]); else pass_cnt++;
        total_cnt++;
        if (st[2:0] !== 3'b011) $display("FAIL store_stall_trace: got %b expected 011", st[2:0]); else pass_cnt++;
        run_access(1'b0, 1'b0, 32'h10, 32'h0, lat, rd, wt, st);
        total_cnt++;
        if (lat != 2) $display("FAIL load_latency: got %0d expected 2", lat); else pass_cnt++;
        total_cnt++;
        if (rd !== ref_mem[4]) $display("FAIL load_data: got %h expected %h", rd, ref_mem[4]); else pass_cnt++;
        total_cnt++;
        if (wt[2:0] !== 3'b000) $display("FAIL load_no_write: got %b expected 000", wt[2:0]); else pass_cnt++;
    endtask

    task automatic test_dma_write_cpu_read();
        int lat; logic [31:0] rd, drd0; logic [7:0] wt, st;
        drd0 = dma_rdata;
        run_access(1'b1, 1'b1, 32'h20, 32'h12345678, lat, rd, wt, st);
        ref_mem[8] = 32'h12345678;
        total_cnt++;
        if (lat != 2) $display("FAIL dma_wr_latency: got %0d expected 2", lat); else pass_cnt++;
        run_access(1'b0, 1'b0, 32'h20, 32'h0, lat, rd, wt, st);
        total_cnt++;
        if (rd !== ref_mem[8]) $display("FAIL cpu_reads_dma_data: got %h expected %h", rd, ref_mem[8]); else pass_cnt++;
        total_cnt++;
        if (dma_rdata !== drd0) $display("FAIL dma_rdata_held: got %h expected %h", dma_rdata, drd0); else pass_cnt++;
    endtask

    task automatic test_contention();
        int cnt; bit exp_dma; int bad_gap;
        mon_cyc.delete(); mon_dma.delete();
        @(posedge clk); #1;
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h40;
        dma_req = 1; dma_we = 0; dma_addr = 32'h44;
        repeat (30) @(posedge clk);
        #1; cpu_req = 0; dma_req = 0;
        repeat (4) @(posedge clk);
        total_cnt++;
        if (mon_cyc.size() != 10) $display("FAIL contention_count: got %0d expected 10", mon_cyc.size());
        else pass_cnt++;
        // Under constant contention DMA wins once the CPU has won LIM times.
        cnt = 0; bad_gap = 0;
        for (int g = 0; g < 10 && g < mon_dma.size(); g++) begin
            exp_dma = (cnt == LIM);
            cnt = exp_dma ? 0 : ((cnt < LIM) ? cnt + 1 : cnt);
            total_cnt++;
            if (mon_dma[g] !== exp_dma) $display("FAIL contention_owner[%0d]: got %0d expected %0d", g, mon_dma[g], exp_dma);
            else pass_cnt++;
            if (g > 0 && (mon_cyc[g] - mon_cyc[g-1]) != 3) bad_gap++;
        end
        total_cnt++;
        if (bad_gap != 0) $display("FAIL contention_spacing: bad gaps=%0d expected 0", bad_gap); else pass_cnt++;
    endtask

    task automatic test_simultaneous();
        bit got_c, got_d;
        mon_cyc.delete(); mon_dma.delete();
        got_c = 0; got_d = 0;
        @(posedge clk); #1;
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
        dma_req = 1; dma_we = 0; dma_addr = 32'h20;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (cpu_ack) begin got_c = 1; break; end
        end
        @(posedge clk); #1; cpu_req = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (dma_ack) begin got_d = 1; break; end
        end
        @(posedge clk); #1; dma_req = 0;
        $display("txn SIM cpu_ack=%0d dma_ack=%0d cpu_rdata=0x%08h dma_rdata=0x%08h", got_c, got_d, cpu_rdata, dma_rdata);
        total_cnt++;
        if (!(got_c && got_d)) $display("FAIL sim_acks: got cpu=%0d dma=%0d expected 1 1", got_c, got_d); else pass_cnt++;
        total_cnt++;
        if (mon_dma.size() != 2 || mon_dma[0] !== 1'b0 || mon_dma[1] !== 1'b1)
            $display("FAIL sim_order: got %0d strobes expected CPU then DMA", mon_dma.size());
        else pass_cnt++;
        total_cnt++;
        if (mon_cyc.size() != 2 || (mon_cyc[1] - mon_cyc[0]) != 3)
            $display("FAIL sim_dma_delay: got %0d strobes expected DMA strobe 3 cycles after CPU", mon_cyc.size());
        else pass_cnt++;
        total_cnt++;
        if (cpu_rdata !== ref_mem[4] || dma_rdata !== ref_mem[8])
            $display("FAIL sim_data: got %h/%h expected %h/%h", cpu_rdata, dma_rdata, ref_mem[4], ref_mem[8]);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_acc();
        int lat; logic [31:0] rd; logic [7:0] wt, st; bit saw_ack;
        @(posedge clk); #1;
        dma_req = 1; dma_we = 1; dma_addr = 32'h30; dma_wdata = 32'hCAFEF00D;
        @(negedge clk);
        @(negedge clk);
        total_cnt++;
        if (mem_we !== 1'b1) $display("FAIL abort_pre_we: got %b expected 1", mem_we); else pass_cnt++;
        #1 reset = 1'b1;
        #1;
        total_cnt++;
        if (mem_we !== 1'b0) $display("FAIL abort_we_drop: got %b expected 0", mem_we); else pass_cnt++;
        dma_req = 0;
        @(negedge clk);
        reset = 1'b0;
        saw_ack = 0;
        repeat (4) begin
            @(negedge clk);
            if (dma_ack) saw_ack = 1;
        end
        total_cnt++;
        if (saw_ack) $display("FAIL abort_no_ack: got dma_ack=1 expected 0"); else pass_cnt++;
        run_access(1'b0, 1'b0, 32'h30, 32'h0, lat, rd, wt, st);
        total_cnt++;
        if (rd !== ref_mem[12] || lat != 2) $display("FAIL abort_mem_intact: got %h lat %0d expected %h lat 2", rd, lat, ref_mem[12]);
        else pass_cnt++;
    endtask

    task automatic test_random();
        int lat; logic [31:0] rd, wd, exp_cpu, exp_dma; logic [7:0] wt, st;
        bit is_dma, we; int idx;
        // State left by the previous test: CPU just loaded word 12, DMA was reset.
        exp_cpu = ref_mem[12];
        exp_dma = 32'h0;
        for (int t = 0; t < 40; t++) begin
            is_dma = 1'($urandom_range(0, 1));
            we = 1'($urandom_range(0, 1));
            idx = $urandom_range(0, 63);
            wd = $urandom;
            run_access(is_dma, we, 32'(idx * 4), wd, lat, rd, wt, st);
            if (we) ref_mem[idx] = wd;
            else if (is_dma) exp_dma = ref_mem[idx];
            else exp_cpu = ref_mem[idx];
            total_cnt++;
            if (lat != 2) $display("FAIL rand_latency[%0d]: got %0d expected 2", t, lat); else pass_cnt++;
            total_cnt++;
            if (cpu_rdata !== exp_cpu || dma_rdata !== exp_dma)
                $display("FAIL rand_rdata[%0d]: got %h/%h expected %h/%h", t, cpu_rdata, dma_rdata, exp_cpu, exp_dma);
            else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_cpu_store_load();
        test_dma_write_cpu_read();
        test_contention();
        test_simultaneous();
        test_reset_mid_acc();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
